cpu_run_ctrl: RTL and testbench

Run/debug sequencer for the 4-bit CPU core. It gates core execution through a clock-enable and can pulse the core's reset. It accepts RUN / STEP / STOP / RESET_CPU commands over a valid/ready handshake. It stops the core on halt, PC breakpoint, cycle timeout or user request, and reports why.

---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/cpu_sat_counter.sv | 32 +++
 rtl/cpu_run_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the run/debug sequencer of the 4-bit CPU core.
// Contents:
//   run_state_e   - sequencer FSM states, also driven out on the state port
//   cmd_op_e      - command opcodes carried on cmd_op
//   stop_reason_e - why the last RUN/STEP ended, driven out on stop_reason
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StStep    = 3'd2,
    StCoreRst = 3'd3,
    StHalted  = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    OpRun      = 2'd0,
    OpStep     = 2'd1,
    OpStop     = 2'd2,
    OpResetCpu = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ReasonNone    = 3'd0,
    ReasonHalt    = 3'd1,
    ReasonBreak   = 3'd2,
    ReasonTimeout = 3'd3,
    ReasonUser    = 3'd4
  } stop_reason_e;

endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low reset (clears the count)
//   clr_i  - synchronous clear, takes priority over en_i
//   en_i   - count enable; the count holds once it reaches all-ones
//   cnt_o  - current count
module cpu_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the 4-bit CPU core. Gates execution through cpu_en, pulses cpu_rst,
// accepts RUN/STEP/STOP/RESET_CPU over a valid/ready handshake and reports why the core stopped.
// Ports:
//   clk, rst (synchronous active-low)
//   cmd_valid/cmd_ready/cmd_op - command handshake (0=RUN 1=STEP 2=STOP 3=RESET_CPU)
//   bp_en/bp_addr              - PC breakpoint
//   cpu_pc/cpu_halt            - core status
//   cpu_en/cpu_rst             - core execute enable and active-high core reset
//   state/stop_reason          - FSM state and last stop reason
//   cycle_cnt                  - saturating count of enabled cycles since last RESET_CPU
//   done                       - one-cycle pulse when a RUN or STEP ends
// Build option CPU_RUN_CTRL_MULTISTEP_EN: adds cmd_arg; STEP then runs max(cmd_arg,1) enabled
// cycles with halt, breakpoint and STOP checked as in RUN.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 0,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
  input  logic [3:0]       cmd_arg,
`endif
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       cpu_pc,
  input  logic             cpu_halt,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [2:0]       state,
  output logic [2:0]       stop_reason,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e      state_q;
  stop_reason_e    reason_q;
  logic            done_q, cpu_rst_q, first_q;
  logic [RstW-1:0] rst_tmr;
  cmd_op_e         op;
  logic            cmd_acc, acc_go, acc_stop, acc_reset;
  logic            bp_hit, timeout, run_stop, enter_rst, rst_last;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
  logic [3:0]      step_q;
  logic            step_stop;
`endif

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign acc_go    = cmd_acc & ((op == OpRun) | (op == OpStep));
  assign acc_stop  = cmd_acc & (op == OpStop);
  assign acc_reset = cmd_acc & (op == OpResetCpu);
  // first_q masks the breakpoint for one cycle so a run can leave a breakpoint PC.
  assign bp_hit    = bp_en & (cpu_pc == bp_addr) & ~first_q;

  if (MAX_CYCLES != 0) begin : g_timeout
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYCLES);
    assign timeout = (cycle_cnt >= MaxCnt);
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  assign run_stop  = cpu_halt | bp_hit | timeout | acc_stop | acc_reset;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
  assign step_stop = cpu_halt | bp_hit | acc_stop;
`endif

  // A halting core wins over RESET_CPU issued in the same RUN cycle.
  assign enter_rst = acc_reset & ((state_q == StIdle) | (state_q == StHalted) |
                                  ((state_q == StRun) & ~cpu_halt));

  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      StIdle, StRun, StHalted: cmd_ready = 1'b1;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
      StStep:                  cmd_ready = (op == OpStop);
`endif
      default:                 cmd_ready = 1'b0;
    endcase
  end

  // Combinational so the stop cycle itself never retires an instruction.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      StRun:   cpu_en = ~run_stop;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
      StStep:  cpu_en = ~step_stop;
`else
      StStep:  cpu_en = ~cpu_halt;
`endif
      default: cpu_en = 1'b0;
    endcase
  end

  cpu_sat_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (enter_rst),
    .en_i   (cpu_en),
    .cnt_o  (cycle_cnt)
  );

  cpu_sat_counter #(
    .Width (RstW)
  ) u_rst_tmr (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (enter_rst),
    .en_i   (state_q == StCoreRst),
    .cnt_o  (rst_tmr)
  );

  assign rst_last = (rst_tmr == RstW'(RST_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      reason_q  <= ReasonNone;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
      first_q   <= 1'b0;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
      step_q    <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (acc_go) begin
            if (cpu_halt) begin
              state_q  <= StHalted;
              reason_q <= ReasonHalt;
              done_q   <= 1'b1;
            end else if (op == OpRun) begin
              state_q <= StRun;
              first_q <= 1'b1;
            end else begin
              state_q <= StStep;
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
              first_q <= 1'b1;
              step_q  <= (cmd_arg == 4'd0) ? 4'd1 : cmd_arg;
`endif
            end
          end else if (acc_reset) begin
            state_q   <= StCoreRst;
            reason_q  <= ReasonNone;
            cpu_rst_q <= 1'b1;
          end
        end
        StRun: begin
          first_q <= 1'b0;
          if (run_stop) begin
            done_q <= 1'b1;
            if (cpu_halt) begin
              state_q  <= StHalted;
              reason_q <= ReasonHalt;
            end else if (acc_reset) begin
              state_q   <= StCoreRst;
              reason_q  <= ReasonNone;
              cpu_rst_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              if (bp_hit)       reason_q <= ReasonBreak;
              else if (timeout) reason_q <= ReasonTimeout;
              else              reason_q <= ReasonUser;
            end
          end
        end
        StStep: begin
`ifdef CPU_RUN_CTRL_MULTISTEP_EN
          first_q <= 1'b0;
          if (step_stop || (step_q == 4'd1)) begin
            done_q <= 1'b1;
            if (cpu_halt) begin
              state_q  <= StHalted;
              reason_q <= ReasonHalt;
            end else begin
              state_q <= StIdle;
              if (bp_hit)        reason_q <= ReasonBreak;
              else if (acc_stop) reason_q <= ReasonUser;
            end
          end else begin
            step_q <= step_q - 4'd1;
          end
`else
          done_q <= 1'b1;
          if (cpu_halt) begin
            state_q  <= StHalted;
            reason_q <= ReasonHalt;
          end else begin
            state_q <= StIdle;
          end
`endif
        end
        StCoreRst: begin
          if (rst_last) begin
            state_q   <= StIdle;
            cpu_rst_q <= 1'b0;
          end
        end
        StHalted: begin
          if (acc_reset) begin
            state_q   <= StCoreRst;
            reason_q  <= ReasonNone;
            cpu_rst_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state       = state_q;
  assign stop_reason = reason_q;
  assign done        = done_q;
  assign cpu_rst     = cpu_rst_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a cycle-level vector table with forced PC/halt, then multi-cycle
// sequences driven by a simple core PC model (advances on cpu_en, cleared by cpu_rst).
// A second instance with MAX_CYCLES=4 covers the timeout path.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_valid_t;
  logic [1:0]  cmd_op;
  logic        bp_en;
  logic [3:0]  bp_addr;
  logic        use_model, halt_force, halt_en;
  logic [3:0]  pc_force, halt_pc;
  logic [3:0]  pc_m, pc_t;
  logic [3:0]  cpu_pc;
  logic        cpu_halt;

  logic        cmd_ready, cpu_en, cpu_rst, done;
  logic [2:0]  state, stop_reason;
  logic [15:0] cycle_cnt;
  logic        cmd_ready_t, cpu_en_t, cpu_rst_t, done_t;
  logic [2:0]  state_t, stop_reason_t;
  logic [15:0] cycle_cnt_t;

  int total = 0;
  int bad = 0;
  int en_seen = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  assign cpu_pc   = use_model ? pc_m : pc_force;
  assign cpu_halt = use_model ? (halt_en && (pc_m == halt_pc)) : halt_force;

  cpu_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .cpu_pc      (cpu_pc),
    .cpu_halt    (cpu_halt),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .state       (state),
    .stop_reason (stop_reason),
    .cycle_cnt   (cycle_cnt),
    .done        (done)
  );

  cpu_run_ctrl #(
    .MAX_CYCLES (4)
  ) dut_to (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid_t),
    .cmd_ready   (cmd_ready_t),
    .cmd_op      (cmd_op),
    .bp_en       (1'b0),
    .bp_addr     (4'd0),
    .cpu_pc      (pc_t),
    .cpu_halt    (1'b0),
    .cpu_en      (cpu_en_t),
    .cpu_rst     (cpu_rst_t),
    .state       (state_t),
    .stop_reason (stop_reason_t),
    .cycle_cnt   (cycle_cnt_t),
    .done        (done_t)
  );

  // Core models: one instruction per enabled edge.
  always @(posedge clk) begin
    if (!rst || cpu_rst) pc_m <= 4'd0;
    else if (cpu_en)     pc_m <= pc_m + 4'd1;
    if (!rst || cpu_rst_t) pc_t <= 4'd0;
    else if (cpu_en_t)     pc_t <= pc_t + 4'd1;
    if (rst && cpu_en) en_seen <= en_seen + 1;
  end

  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic        halt;
    logic        bpe;
    logic [3:0]  bpa;
    logic [3:0]  pc;
    logic        en;
    logic        rdy;
    logic [2:0]  st;
    logic [2:0]  rsn;
    logic        dn;
    logic        crst;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int v, input int op, input int h, input int be,
                              input int ba, input int pc, input int en, input int rdy,
                              input int st, input int rs, input int dn, input int cr,
                              input int cnt);
    vec_t r;
    r.v = 1'(v);     r.op = 2'(op);  r.halt = 1'(h);  r.bpe = 1'(be);
    r.bpa = 4'(ba);  r.pc = 4'(pc);  r.en = 1'(en);   r.rdy = 1'(rdy);
    r.st = 3'(st);   r.rsn = 3'(rs); r.dn = 1'(dn);   r.crst = 1'(cr);
    r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic issue(input bit sel, input logic [1:0] op);
    @(negedge clk);
    cmd_op = op;
    if (sel) cmd_valid_t = 1'b1;
    else     cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_valid_t = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int max);
    int n;
    n = 0;
    while (((sel ? done_t : done) !== 1'b1) && (n < max)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int base_en, base_done, rst_hi;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid_t = 1'b0; cmd_op = 2'd0;
    bp_en = 1'b0; bp_addr = 4'd0; use_model = 1'b0; pc_force = 4'd0;
    halt_force = 1'b0; halt_en = 1'b0; halt_pc = 4'd0;

    //                 v op h be ba pc  en rdy st rs dn cr cnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,  0, 0, 0, 0, 0));  // idle
    tbl.push_back(mk(1, 2, 0, 0, 0, 0,  0, 1,  0, 0, 0, 0, 0));  // STOP in idle
    tbl.push_back(mk(1, 0, 0, 1, 0, 0,  0, 1,  1, 0, 0, 0, 0));  // RUN
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 1,  1, 0, 0, 0, 1));  // bp masked first cycle
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 1,  1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1,  0, 2, 1, 0, 2));  // breakpoint
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,  0, 2, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 1,  4, 1, 1, 0, 2));  // RUN while halted core
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1,  4, 1, 0, 0, 2));  // RUN ignored
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1,  4, 1, 0, 0, 2));  // STEP ignored
    tbl.push_back(mk(1, 3, 0, 0, 0, 0,  0, 1,  3, 0, 0, 1, 0));  // RESET_CPU
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  3, 0, 0, 1, 0));  // not ready
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1,  2, 0, 0, 0, 0));  // STEP
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0,  0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1,  2, 0, 0, 0, 1));  // STEP into halt
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0,  4, 1, 1, 0, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0,  0, 1,  3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0,  0, 1,  1, 0, 0, 0, 0));  // RUN
    tbl.push_back(mk(0, 0, 0, 1, 5, 2,  1, 1,  1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 5, 5,  0, 1,  4, 1, 1, 0, 1));  // halt + bp together
    tbl.push_back(mk(1, 3, 0, 0, 0, 0,  0, 1,  3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1,  1, 0, 0, 0, 0));  // RUN
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1,  1, 0, 0, 0, 1));  // RUN in RUN ignored
    tbl.push_back(mk(1, 2, 0, 0, 0, 1,  0, 1,  0, 4, 1, 0, 1));  // STOP
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1,  1, 4, 0, 0, 1));  // RUN
    tbl.push_back(mk(1, 3, 0, 0, 0, 0,  0, 1,  3, 0, 1, 1, 0));  // RESET_CPU in RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));

    do_reset();
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_reason", 32'(stop_reason), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_state_t", 32'(state_t), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      cmd_valid = tbl[i].v;   cmd_op = tbl[i].op;   halt_force = tbl[i].halt;
      bp_en = tbl[i].bpe;     bp_addr = tbl[i].bpa; pc_force = tbl[i].pc;
      #1;
      chk($sformatf("v%0d_en", i), 32'(cpu_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("v%0d_reason", i), 32'(stop_reason), 32'(tbl[i].rsn));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].crst));
      chk($sformatf("v%0d_cnt", i), 32'(cycle_cnt), 32'(tbl[i].cnt));
    end
    cmd_valid = 1'b0; bp_en = 1'b0; halt_force = 1'b0;

    // Run until the core halts at PC=5.
    use_model = 1'b1; halt_en = 1'b1; halt_pc = 4'd5;
    do_reset();
    base_en = en_seen;
    issue(0, 2'd0);
    wait_done(0, 40);
    chk("halt_done", 32'(done), 1);
    chk("halt_state", 32'(state), 4);
    chk("halt_reason", 32'(stop_reason), 1);
    chk("halt_cnt", 32'(cycle_cnt), 5);
    chk("halt_pc", 32'(pc_m), 5);
    chk("halt_en_pulses", 32'(en_seen - base_en), 5);
    @(posedge clk);
    #1;
    chk("halt_done_one_cycle", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_en_stays_off", 32'(en_seen - base_en), 5);

    // HALTED ignores RUN; RESET_CPU holds cpu_rst for two cycles.
    issue(0, 2'd0);
    chk("halted_run_ignored", 32'(state), 4);
    chk("halted_en_off", 32'(cpu_en), 0);
    issue(0, 2'd3);
    rst_hi = cpu_rst ? 1 : 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (cpu_rst) rst_hi++;
    end
    chk("core_rst_len", 32'(rst_hi), 2);
    chk("core_rst_state", 32'(state), 0);
    chk("core_rst_cnt", 32'(cycle_cnt), 0);
    chk("core_rst_reason", 32'(stop_reason), 0);
    chk("core_rst_pc", 32'(pc_m), 0);
    halt_en = 1'b0;

    // Breakpoint at 3, then resume past it and stop by user.
    do_reset();
    bp_en = 1'b1; bp_addr = 4'd3;
    issue(0, 2'd0);
    wait_done(0, 40);
    chk("bp_done", 32'(done), 1);
    chk("bp_state", 32'(state), 0);
    chk("bp_reason", 32'(stop_reason), 2);
    chk("bp_cnt", 32'(cycle_cnt), 3);
    chk("bp_pc", 32'(pc_m), 3);
    issue(0, 2'd0);
    @(posedge clk);
    #1;
    chk("bp_resume_pc", 32'(pc_m), 4);
    issue(0, 2'd2);
    wait_done(0, 10);
    chk("bp_stop_done", 32'(done), 1);
    chk("bp_stop_reason", 32'(stop_reason), 4);
    chk("bp_stop_cnt", 32'(cycle_cnt), 4);
    bp_en = 1'b0;

    // Three single steps.
    do_reset();
    base_en = en_seen;
    base_done = done_seen;
    for (int k = 0; k < 3; k++) begin
      issue(0, 2'd1);
      @(negedge clk);
      chk($sformatf("step%0d_en", k), 32'(cpu_en), 1);
      chk($sformatf("step%0d_ready", k), 32'(cmd_ready), 0);
      @(posedge clk);
      #1;
      chk($sformatf("step%0d_done", k), 32'(done), 1);
      chk($sformatf("step%0d_state", k), 32'(state), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("step_pc", 32'(pc_m), 3);
    chk("step_en_pulses", 32'(en_seen - base_en), 3);
    chk("step_done_pulses", 32'(done_seen - base_done), 3);

    // Timeout instance.
    do_reset();
    issue(1, 2'd0);
    wait_done(1, 40);
    chk("to_done", 32'(done_t), 1);
    chk("to_state", 32'(state_t), 0);
    chk("to_reason", 32'(stop_reason_t), 3);
    chk("to_cnt", 32'(cycle_cnt_t), 4);
    chk("to_pc", 32'(pc_t), 4);
    do_reset();
    issue(1, 2'd0);
    repeat (2) @(posedge clk);
    issue(1, 2'd2);
    wait_done(1, 10);
    chk("to_stop_done", 32'(done_t), 1);
    chk("to_stop_reason", 32'(stop_reason_t), 4);
    chk("to_stop_cnt", 32'(cycle_cnt_t), 2);

    // Reset asserted mid-RUN.
    do_reset();
    issue(0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_en_before", 32'(cpu_en), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_en", 32'(cpu_en), 0);
    chk("mid_rst_cnt", 32'(cycle_cnt), 0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
